// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V sequencing controller: a Moore FSM that steps one instruction
// through fetch, decode, execute, memory and writeback over a single shared memory
// port. It also counts retired instructions and traps on an illegal opcode or a
// memory access that waits too long.
module multicycle_control_fsm #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN,
    input  logic [6:0]       OPE_CODE,
    input  logic             ZERO,
    input  logic             MEM_READY,
    output logic             PC_WRITE,
    output logic             IR_WRITE,
    output logic             ADR_SRC,
    output logic             MEM_READ,
    output logic             MEM_WRITE,
    output logic             REG_WRITE,
    output logic [1:0]       IMM_SRC,
    output logic [1:0]       ALU_SRC_A,
    output logic [1:0]       ALU_SRC_B,
    output logic [1:0]       ALU_OP,
    output logic [1:0]       RESULT_SRC,
    output logic             BUSY,
    output logic             TRAP,
    output logic [CNT_W-1:0] INSTRET
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    // Last stall cycle tolerated before giving up on the memory.
    localparam logic [7:0] WaitLast = 8'(MEM_WAIT_MAX - 1);

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBeq,
        StJal,
        StTrap
    } state_e;

    // Registered per-state controls; fetch/beq/jal are qualifiers combined later
    // with MEM_READY and ZERO, which must act within the same cycle.
    typedef struct packed {
        logic       fetch;
        logic       beq;
        logic       jal;
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] imm_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       busy;
        logic       trap;
    } ctl_t;

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    ctl_t             ctl_q, ctl_d;
    logic             retire;
    logic             stall;

    // Next state, memory wait counter and retire counter.
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        instret_d = instret_q;
        retire    = 1'b0;
        stall     = 1'b0;
        case (state_q)
            StIdle: begin
                if (RUN) state_d = StFetch;
            end
            StFetch: begin
                if (MEM_READY) state_d = StDecode;
                else           stall   = 1'b1;
            end
            StDecode: begin
                case (OPE_CODE)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpBranch:        state_d = StBeq;
                    OpJal:           state_d = StJal;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                state_d = (OPE_CODE == OpStore) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                if (MEM_READY) state_d = StMemWb;
                else           stall   = 1'b1;
            end
            StMemWrite: begin
                if (MEM_READY) retire = 1'b1;
                else           stall  = 1'b1;
            end
            StExecR, StExecI, StJal: begin
                state_d = StAluWb;
            end
            StMemWb, StAluWb, StBeq: begin
                retire = 1'b1;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StTrap;
            end
        endcase
        // Instruction end: count it, then continue or park depending on RUN.
        if (retire) begin
            instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_d   = RUN ? StFetch : StIdle;
        end
        // Counter only survives while stalling in the same access; any move clears it.
        if (stall) begin
            if (wait_q == WaitLast) state_d = StTrap;
            else                    wait_d  = wait_q + 8'd1;
        end
    end

    // Moore decode of the state being entered, so every control comes from a flop.
    always_comb begin
        ctl_d = '0;
        case (state_d)
            StFetch: begin
                ctl_d.fetch      = 1'b1;
                ctl_d.mem_read   = 1'b1;
                ctl_d.alu_src_b  = 2'b10;
                ctl_d.result_src = 2'b10;
            end
            StDecode: begin
                ctl_d.alu_src_a = 2'b01;
                ctl_d.alu_src_b = 2'b01;
                ctl_d.imm_src   = 2'b10;
            end
            StMemAdr: begin
                ctl_d.alu_src_a = 2'b10;
                ctl_d.alu_src_b = 2'b01;
                ctl_d.imm_src   = (OPE_CODE == OpStore) ? 2'b01 : 2'b00;
            end
            StMemRead: begin
                ctl_d.adr_src  = 1'b1;
                ctl_d.mem_read = 1'b1;
            end
            StMemWb: begin
                ctl_d.result_src = 2'b01;
                ctl_d.reg_write  = 1'b1;
            end
            StMemWrite: begin
                ctl_d.adr_src   = 1'b1;
                ctl_d.mem_write = 1'b1;
            end
            StExecR: begin
                ctl_d.alu_src_a = 2'b10;
                ctl_d.alu_op    = 2'b10;
            end
            StExecI: begin
                ctl_d.alu_src_a = 2'b10;
                ctl_d.alu_src_b = 2'b01;
                ctl_d.alu_op    = 2'b10;
            end
            StAluWb: begin
                ctl_d.reg_write = 1'b1;
            end
            StBeq: begin
                ctl_d.alu_src_a = 2'b10;
                ctl_d.alu_op    = 2'b01;
                ctl_d.beq       = 1'b1;
            end
            StJal: begin
                ctl_d.alu_src_a = 2'b01;
                ctl_d.alu_src_b = 2'b10;
                ctl_d.jal       = 1'b1;
            end
            StTrap: begin
                ctl_d.trap = 1'b1;
            end
            default: begin
                ctl_d = '0;
            end
        endcase
        ctl_d.busy = (state_d != StIdle) && (state_d != StTrap);
    end

    // State, counters and registered controls; async reset drops every strobe at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            instret_q <= '0;
            ctl_q     <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            ctl_q     <= ctl_d;
        end
    end

    assign PC_WRITE   = (ctl_q.fetch & MEM_READY) | ctl_q.jal | (ctl_q.beq & ZERO);
    assign IR_WRITE   = ctl_q.fetch & MEM_READY;
    assign ADR_SRC    = ctl_q.adr_src;
    assign MEM_READ   = ctl_q.mem_read;
    assign MEM_WRITE  = ctl_q.mem_write;
    assign REG_WRITE  = ctl_q.reg_write;
    assign IMM_SRC    = ctl_q.imm_src;
    assign ALU_SRC_A  = ctl_q.alu_src_a;
    assign ALU_SRC_B  = ctl_q.alu_src_b;
    assign ALU_OP     = ctl_q.alu_op;
    assign RESULT_SRC = ctl_q.result_src;
    assign BUSY       = ctl_q.busy;
    assign TRAP       = ctl_q.trap;
    assign INSTRET    = instret_q;

endmodule
